// File: rtl/regfile_wb_arb.sv
// Merges ALU and load writebacks into one register-file write port through
// two per-source FIFOs and a round-robin arbiter; one registered write per cycle.

module regfile_wb_fifo #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic          rdy_o,
    output logic          vld_o,
    output logic [AW-1:0] addr_o,
    output logic [DW-1:0] data_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [AW+DW-1:0] mem_q [DEPTH];
    logic             do_push;

    // Ready and valid come only from the registered count.
    assign rdy_o   = (cnt_q != CW'(DEPTH));
    assign vld_o   = (cnt_q != '0);
    assign do_push = push_i && rdy_o;

    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !pop_i) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!do_push && pop_i) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_i)   rd_ptr_q <= rd_ptr_q + PW'(1);
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= {addr_i, data_i};
    end

    assign {addr_o, data_o} = mem_q[rd_ptr_q];
endmodule

module regfile_wb_arb #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          aValid,
    input  logic [AW-1:0] aAddr,
    input  logic [DW-1:0] aData,
    output logic          aReady,
    input  logic          bValid,
    input  logic [AW-1:0] bAddr,
    input  logic [DW-1:0] bData,
    output logic          bReady,
    output logic          write,
    output logic [AW-1:0] wrAddr,
    output logic [DW-1:0] wrData,
    output logic          busy
);
    logic          a_vld, b_vld, a_pop, b_pop, grant_a;
    logic [AW-1:0] a_head_addr, b_head_addr;
    logic [DW-1:0] a_head_data, b_head_data;
    logic          write_q, last_b_q;
    logic [AW-1:0] wr_addr_q;
    logic [DW-1:0] wr_data_q;

    regfile_wb_fifo #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_fifo_a (
        .clk(clk), .reset(reset),
        .push_i(aValid), .addr_i(aAddr), .data_i(aData),
        .pop_i(a_pop), .rdy_o(aReady), .vld_o(a_vld),
        .addr_o(a_head_addr), .data_o(a_head_data)
    );

    regfile_wb_fifo #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_fifo_b (
        .clk(clk), .reset(reset),
        .push_i(bValid), .addr_i(bAddr), .data_i(bData),
        .pop_i(b_pop), .rdy_o(bReady), .vld_o(b_vld),
        .addr_o(b_head_addr), .data_o(b_head_data)
    );

    // last_b_q set means B won most recently, so A takes the next tie.
    assign grant_a = a_vld && (!b_vld || last_b_q);
    assign a_pop   = grant_a;
    assign b_pop   = b_vld && !grant_a;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            write_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            last_b_q  <= 1'b1;
        end else if (a_vld || b_vld) begin
            write_q   <= 1'b1;
            wr_addr_q <= grant_a ? a_head_addr : b_head_addr;
            wr_data_q <= grant_a ? a_head_data : b_head_data;
            last_b_q  <= !grant_a;
        end else begin
            write_q <= 1'b0;
        end
    end

    assign write  = write_q;
    assign wrAddr = wr_addr_q;
    assign wrData = wr_data_q;
    assign busy   = a_vld || b_vld || write_q;
endmodule

// File: tb/tb_regfile_wb_arb.sv
// Randomised and directed bench for regfile_wb_arb against a queue-based reference model.

module tb_regfile_wb_arb;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          aValid = 1'b0, bValid = 1'b0;
    logic [AW-1:0] aAddr = '0, bAddr = '0;
    logic [DW-1:0] aData = '0, bData = '0;
    logic          aReady, bReady, write, busy;
    logic [AW-1:0] wrAddr;
    logic [DW-1:0] wrData;

    regfile_wb_arb #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .aValid(aValid), .aAddr(aAddr), .aData(aData), .aReady(aReady),
        .bValid(bValid), .bAddr(bAddr), .bData(bData), .bReady(bReady),
        .write(write), .wrAddr(wrAddr), .wrData(wrData), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: two queues, a last-grant flag and the registered port.
    ent_t          qa[$], qb[$];
    logic          m_write = 1'b0, m_last_b = 1'b1;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    logic          pa, pb, ga;
    ent_t          e;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            qa.delete();
            qb.delete();
            m_write  = 1'b0;
            m_addr   = '0;
            m_data   = '0;
            m_last_b = 1'b1;
        end else begin
            pa = aValid && (qa.size() < DEPTH);
            pb = bValid && (qb.size() < DEPTH);
            if (qa.size() != 0 || qb.size() != 0) begin
                ga = (qa.size() != 0) && (qb.size() == 0 || m_last_b);
                if (ga) e = qa.pop_front();
                else    e = qb.pop_front();
                m_write  = 1'b1;
                m_addr   = e.addr;
                m_data   = e.data;
                m_last_b = !ga;
            end else begin
                m_write = 1'b0;
            end
            if (pa) qa.push_back({aAddr, aData});
            if (pb) qb.push_back({bAddr, bData});
        end
    end

    logic [DW-1:0] rf [32];
    always @(posedge clk) begin
        if (write === 1'b1) rf[wrAddr] <= wrData;
    end

    logic          chk_en = 1'b0;
    logic          log_en = 1'b0;
    logic          saw_a_full = 1'b0;
    logic [DW-1:0] wlog[$];

    always @(negedge clk) begin
        if (chk_en) begin
            chk("write",  64'(write),  64'(m_write));
            chk("wrAddr", 64'(wrAddr), 64'(m_addr));
            chk("wrData", 64'(wrData), 64'(m_data));
            chk("aReady", 64'(aReady), 64'(qa.size() < DEPTH));
            chk("bReady", 64'(bReady), 64'(qb.size() < DEPTH));
            chk("busy",   64'(busy),   64'(qa.size() != 0 || qb.size() != 0 || m_write));
            if (log_en && write === 1'b1) wlog.push_back(wrData);
            if (aReady === 1'b0) saw_a_full = 1'b1;
        end
    end

    task automatic step(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
        aValid = av; aAddr = aa; aData = ad;
        bValid = bv; bAddr = ba; bData = bd;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic do_reset();
        #2;
        reset  = 1'b0;
        aValid = 1'b0;
        bValid = 1'b0;
        #1;
        chk("rst_write",  64'(write),  64'd0);
        chk("rst_wrAddr", 64'(wrAddr), 64'd0);
        chk("rst_wrData", 64'(wrData), 64'd0);
        chk("rst_aReady", 64'(aReady), 64'd1);
        chk("rst_bReady", 64'(bReady), 64'd1);
        chk("rst_busy",   64'(busy),   64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    int ia, ib, na;
    logic a_acc, b_acc;
    logic [DW-1:0] expv;

    initial begin
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        do_reset();

        // Single entry from A: visible one edge after the push edge.
        step(1'b1, 5'd1, 32'habcdefab, 1'b0, '0, '0);
        chk("single_wait_write", 64'(write), 64'd0);
        chk("single_wait_busy",  64'(busy),  64'd1);
        idle(1);
        chk("single_write",  64'(write),  64'd1);
        chk("single_wrAddr", 64'(wrAddr), 64'd1);
        chk("single_wrData", 64'(wrData), 64'habcdefab);
        idle(1);
        chk("single_done_write", 64'(write),  64'd0);
        chk("single_done_busy",  64'(busy),   64'd0);
        chk("single_hold_data",  64'(wrData), 64'habcdefab);

        // Tie after reset: A first, B on the following cycle.
        do_reset();
        step(1'b1, 5'd2, 32'h11111111, 1'b1, 5'd3, 32'h22222222);
        idle(1);
        chk("tie_first_write", 64'(write),  64'd1);
        chk("tie_first_addr",  64'(wrAddr), 64'd2);
        chk("tie_first_data",  64'(wrData), 64'h11111111);
        idle(1);
        chk("tie_second_write", 64'(write),  64'd1);
        chk("tie_second_addr",  64'(wrAddr), 64'd3);
        chk("tie_second_data",  64'(wrData), 64'h22222222);
        idle(1);
        chk("tie_idle_write", 64'(write), 64'd0);

        // Both sources streaming; sources advance only on acceptance.
        do_reset();
        wlog.delete();
        log_en = 1'b1;
        ia = 0; ib = 0;
        for (int i = 0; i < 8; i++) begin
            a_acc = aReady; b_acc = bReady;
            step(1'b1, 5'd4, 32'hA0000000 + ia, 1'b1, 5'd5, 32'hB0000000 + ib);
            if (a_acc) ia++;
            if (b_acc) ib++;
        end
        idle(12);
        log_en = 1'b0;
        chk("stream_count", 64'(wlog.size()), 64'(ia + ib));
        for (int k = 0; k < 8; k++) begin
            expv = (k % 2 == 0) ? 32'hA0000000 + k / 2 : 32'hB0000000 + k / 2;
            chk("stream_order", (k < wlog.size()) ? 64'(wlog[k]) : 64'hdead, 64'(expv));
        end

        // Fill A while B competes; A must report full and keep its order.
        do_reset();
        wlog.delete();
        saw_a_full = 1'b0;
        log_en = 1'b1;
        ia = 0; ib = 0;
        for (int i = 0; i < 12; i++) begin
            a_acc = aReady; b_acc = bReady;
            step(1'b1, 5'd6, 32'hA0000000 + ia, 1'b1, 5'd7, 32'hB0000000 + ib);
            if (a_acc) ia++;
            if (b_acc) ib++;
        end
        idle(12);
        log_en = 1'b0;
        chk("fill_aReady_low", 64'(saw_a_full), 64'd1);
        na = 0;
        foreach (wlog[k]) begin
            if (wlog[k][31:28] == 4'hA) begin
                chk("fill_a_order", 64'(wlog[k]), 64'(32'hA0000000 + na));
                na++;
            end
        end
        chk("fill_a_count", 64'(na), 64'(ia));

        // Reset mid-stream with three entries queued.
        do_reset();
        step(1'b1, 5'd9, 32'h0000aaaa, 1'b1, 5'd10, 32'h0000bbbb);
        step(1'b1, 5'd9, 32'h0000cccc, 1'b1, 5'd10, 32'h0000dddd);
        chk("midrst_busy_before", 64'(busy), 64'd1);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            idle(1);
            chk("midrst_no_stale_write", 64'(write), 64'd0);
        end

        // Same destination from both sources: last issued value wins.
        do_reset();
        step(1'b1, 5'd8, 32'h01234567, 1'b0, '0, '0);
        step(1'b0, '0, '0, 1'b1, 5'd8, 32'h89abcdef);
        chk("same_first_data", 64'(wrData), 64'h01234567);
        chk("same_first_addr", 64'(wrAddr), 64'd8);
        idle(1);
        chk("same_second_write", 64'(write),  64'd1);
        chk("same_second_data",  64'(wrData), 64'h89abcdef);
        idle(1);
        chk("same_rf8", 64'(rf[8]), 64'h89abcdef);

        // Random traffic with varying load and occasional resets.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                int lim;
                lim = (i / 100) % 3;
                step($urandom_range(0, 2) <= lim, AW'($urandom), $urandom,
                     $urandom_range(0, 2) <= lim, AW'($urandom), $urandom);
            end
        end
        idle(12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
